// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write port arbiter.
// Requester 0 (ALU writeback) and requester 1 (load writeback) share one
// register-file write port. Ties are broken round-robin. Writes to address
// 0 are accepted but never reach the register file.
// Optional feature macro RF_CLEAR_EN: after reset, sweep zeros into every
// register (busy high) before accepting any requests.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  logic              run;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef RF_CLEAR_EN
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;

  // State register; reset always restarts the clear sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  // Sweep address counter, advances once per CLEAR cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + ADDR_W'(1);
  end

  // Leave CLEAR once the highest address has been written
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == {ADDR_W{1'b1}}) state_nxt = RUN;
  end

  // Decode state into arbiter enable and sweep write controls
  always_comb begin
    run      = (state == RUN);
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR) & rst;
    clr_addr = cnt;
  end
`else
  assign run      = 1'b1;
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  // Round-robin grant: on a tie, the requester not served last time wins
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & ~grant0;
    req0_ready = grant0 & run & rst;
    req1_ready = grant1 & run & rst;
    hs         = req0_ready | req1_ready;
    sel_addr   = req1_ready ? req1_addr : req0_addr;
    sel_data   = req1_ready ? req1_data : req0_data;
  end

  // Remember who won the last handshake; reset value lets req0 win first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    last_grant <= 1'b1;
    else if (hs) last_grant <= req1_ready;
  end

  // ---- stage p1: registered write port ----
  // Capture the accepted write; x0 writes are swallowed here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (hs) begin
      we_p1    <= (sel_addr != '0);
      addr_p1  <= sel_addr;
      wdata_p1 <= sel_data;
    end else begin
      we_p1    <= 1'b0;
    end
  end

  // Sweep writes take over the port while clearing
  always_comb begin
    rf_we    = clr_we | we_p1;
    rf_addr  = clr_we ? clr_addr : addr_p1;
    rf_wdata = clr_we ? '0 : wdata_p1;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-address width (2**ADDR_W registers).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0_valid  input  1  SHALL indicate that requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  ADDR_W  SHALL carry the requester 0 destination register.
REQ-007 req0_data  input  DATA_W  SHALL carry the requester 0 write data.
REQ-008 req0_ready  output  1  SHALL indicate that the requester 0 write is accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready SHALL have the same widths and meanings for requester 1 (load writeback).
REQ-010 rf_we  output  1  SHALL drive the register-file write enable.
REQ-011 rf_addr  output  ADDR_W  SHALL drive the register-file write address.
REQ-012 rf_wdata  output  DATA_W  SHALL drive the register-file write data.
REQ-013 busy  output  1  SHALL be high while the clear sweep runs.

Function
REQ-014 States SHALL be CLEAR and RUN.
REQ-015 A handshake SHALL occur on a cycle where reqN_valid and reqN_ready are both 1.
REQ-016 Requesters SHALL hold valid, addr and data stable until the handshake; a requester SHALL NOT wait on ready before asserting valid.
REQ-017 reqN_ready SHALL be combinational: 1 only in RUN when requester N is granted.
REQ-018 In RUN, exactly one requester SHALL be granted per cycle when any valid is high; with a single valid, that requester SHALL be granted.
REQ-019 When both valids are high, the requester not granted at the previous handshake SHALL be granted (round-robin via a last_grant flag); after reset, requester 0 SHALL win the first tie.
REQ-020 last_grant SHALL update only on a handshake.
REQ-021 rf_we, rf_addr and rf_wdata SHALL be registered: a handshake in cycle T SHALL produce rf_we=1 with the accepted addr and data in cycle T+1.
REQ-022 A handshake with addr==0 SHALL be accepted, and rf_we SHALL be 0 in T+1 (x0 write suppressed).
REQ-023 rf_we SHALL be 0 in any RUN cycle that follows a cycle with no handshake; rf_addr and rf_wdata SHALL hold their last values.
REQ-024 Sustained throughput SHALL be one write per cycle; under continuous two-way contention, grants SHALL alternate 0,1,0,1.

Reset
REQ-025 While rst=0: rf_we=0, rf_addr=0, rf_wdata=0, both ready=0, last_grant=1, sweep counter=0, with no clock edge required.
REQ-026 busy SHALL be 1 during reset if RF_CLEAR_EN is defined, otherwise 0.
REQ-027 The reset state SHALL be CLEAR if RF_CLEAR_EN is defined, otherwise RUN.
REQ-028 Reset asserted mid-sweep or mid-transfer SHALL abort the operation; no write in flight is preserved, and the sweep restarts from address 0 on release.

Configuration
REQ-029 Macro RF_CLEAR_EN defined: CLEAR SHALL write 0 to addresses 0..2**ADDR_W-1, one per cycle starting in the first cycle after rst release (rf_we=1, rf_addr=counter, rf_wdata=0).
REQ-030 With RF_CLEAR_EN defined, the sweep SHALL take 32 cycles at default parameters, busy SHALL fall after the last address is written, ready SHALL stay 0 throughout, and the FSM SHALL then enter RUN.
REQ-031 Macro RF_CLEAR_EN undefined: no CLEAR state or counter SHALL exist, busy SHALL be tied 0, and the block SHALL enter RUN directly out of reset.

Verification
REQ-032 RF_CLEAR_EN on, release rst -> rf_we=1 for 32 cycles with rf_addr 0..31 and rf_wdata=0; busy=0 and ready usable on cycle 33.
REQ-033 req0_valid only, addr=5, data=0x14 -> req0_ready=1 the same cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=0x14.
REQ-034 Both valid continuously (req0 addr 3 data 0xA, req1 addr 4 data 0xB, each new after its handshake) -> first grant to req0, then strict alternation; rf_we stays 1 every cycle.
REQ-035 req1_valid, addr=0, data=0xFFFFFFFF -> req1_ready=1; next cycle rf_we=0.
REQ-036 Assert rst at sweep address 10 and again one cycle after a handshake -> outputs zero immediately; the sweep restarts at address 0 and the pending write is never issued.
REQ-037 RF_CLEAR_EN off -> busy=0 always; a req0 write issued in the first cycle after rst release is accepted that cycle.
